// File: rtl/esm_dep_tracker.sv
// esm_dep_tracker
//
// Tracks the instructions held in the instruction buffer and reports which
// of them are free to issue. Each slot stores its decoded register fields
// and a dependency row. The row marks the older entries that the slot must
// wait for. RAW hazards are always tracked. WAW and WAR tracking are enabled
// by DEP_MODE[0] and DEP_MODE[1].
//
// Slot 0 is the leftmost (MSB) bit of every [0:BS-1] vector.
//
// Parameters:
//   INSTR_W   instruction word width (rd [11:7], rs1 [19:15], rs2 [24:20])
//   BS        buffer entries, power of two, at least 2
//   REGNUM    architectural registers; register 0 never creates a dependency
//   DEP_MODE  bit0 enables WAW tracking, bit1 enables WAR tracking
//
// Ports:
//   clk                rising-edge clock
//   rst                asynchronous active-high reset
//   ins_valid          insert strobe
//   ins_index          target slot of the insert
//   ins_instr          instruction word to insert
//   ins_regwrite       instruction writes rd (rd is treated as 0 otherwise)
//   ins_alusrc         rs2 is unused and treated as 0
//   ret_valid          retire strobe
//   ret_index          slot to retire
//   flush              synchronous clear of all entries
//   valid_entries      occupied-slot mask
//   independent_instr  valid entries with no outstanding dependency
//   occupancy          number of valid entries
//   ins_error          one-cycle pulse after a rejected insert

module esm_dep_tracker #(
    parameter int         INSTR_W  = 32,
    parameter int         BS       = 16,
    parameter int         REGNUM   = 32,
    parameter logic [1:0] DEP_MODE = 2'b00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ins_valid,
    input  logic [$clog2(BS)-1:0]     ins_index,
    input  logic [INSTR_W-1:0]        ins_instr,
    input  logic                      ins_regwrite,
    input  logic                      ins_alusrc,
    input  logic                      ret_valid,
    input  logic [$clog2(BS)-1:0]     ret_index,
    input  logic                      flush,
    output logic [0:BS-1]             valid_entries,
    output logic [0:BS-1]             independent_instr,
    output logic [$clog2(BS+1)-1:0]   occupancy,
    output logic                      ins_error
);

    localparam int IW = $clog2(BS);
    localparam int RW = $clog2(REGNUM);
    localparam int OW = $clog2(BS+1);

    logic [0:BS-1]   valid_q;
    logic [0:BS-1]   valid_d;
    logic [0:BS-1]   dep_q [BS];
    logic [0:BS-1]   dep_d [BS];
    logic [RW-1:0]   rd_q  [BS];
    logic [RW-1:0]   rs1_q [BS];
    logic [RW-1:0]   rs2_q [BS];
    logic [OW-1:0]   occ_q;
    logic [OW-1:0]   occ_d;
    logic            err_q;
    logic            err_d;

    logic [RW-1:0]   new_rd;
    logic [RW-1:0]   new_rs1;
    logic [RW-1:0]   new_rs2;
    logic            ret_eff;
    logic            slot_free;
    logic            ins_ok;
    logic [0:BS-1]   older;
    logic [0:BS-1]   new_row;
    logic            unused_instr;

    // Only the low RW bits of each 5-bit register field are kept, so a
    // smaller REGNUM simply narrows the stored fields.
    always_comb begin
        new_rd  = ins_regwrite ? ins_instr[7 +: RW] : '0;
        new_rs1 = ins_instr[15 +: RW];
        new_rs2 = ins_alusrc ? '0 : ins_instr[20 +: RW];
    end

    // Opcode and funct bits carry no register information.
    assign unused_instr = ^ins_instr;

    // A same-cycle retire of the target slot frees it for the insert, even
    // when that retire finds the slot already empty.
    always_comb begin
        ret_eff   = ret_valid & valid_q[ret_index];
        slot_free = ~valid_q[ins_index] | (ret_valid & (ret_index == ins_index));
        ins_ok    = ins_valid & slot_free;
    end

    // Dependency row of the entry being inserted. An entry retired on this
    // edge no longer counts as older. The target slot itself is excluded.
    always_comb begin
        older   = valid_q;
        new_row = '0;
        if (ret_eff) begin
            older[ret_index] = 1'b0;
        end
        for (int j = 0; j < BS; j++) begin
            if (older[j] && (IW'(j) != ins_index)) begin
                new_row[j] =
                    ((rd_q[j] != '0) && ((rd_q[j] == new_rs1) || (rd_q[j] == new_rs2)))
                 || (DEP_MODE[0] && (new_rd != '0) && (new_rd == rd_q[j]))
                 || (DEP_MODE[1] && (new_rd != '0) &&
                     ((new_rd == rs1_q[j]) || (new_rd == rs2_q[j])));
            end
        end
    end

    // Next state. The retire is applied first, then the insert, so a slot
    // that is retired and re-filled on the same edge ends up valid with its
    // new row. Flush overrides both.
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        err_d   = ins_valid & ~slot_free;
        for (int k = 0; k < BS; k++) begin
            dep_d[k] = dep_q[k];
        end
        if (ret_eff) begin
            valid_d[ret_index] = 1'b0;
            for (int k = 0; k < BS; k++) begin
                dep_d[k][ret_index] = 1'b0;
            end
            dep_d[ret_index] = '0;
        end
        if (ins_ok) begin
            valid_d[ins_index] = 1'b1;
            dep_d[ins_index]   = new_row;
        end
        if (ins_ok && !ret_eff) begin
            occ_d = occ_q + OW'(1);
        end else if (!ins_ok && ret_eff) begin
            occ_d = occ_q - OW'(1);
        end
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
            err_d   = 1'b0;
            for (int k = 0; k < BS; k++) begin
                dep_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < BS; k++) begin
                dep_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
            for (int k = 0; k < BS; k++) begin
                dep_q[k] <= dep_d[k];
            end
        end
    end

    // Register fields matter only while the slot is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BS; k++) begin
                rd_q[k]  <= '0;
                rs1_q[k] <= '0;
                rs2_q[k] <= '0;
            end
        end else if (ins_ok && !flush) begin
            rd_q[ins_index]  <= new_rd;
            rs1_q[ins_index] <= new_rs1;
            rs2_q[ins_index] <= new_rs2;
        end
    end

    always_comb begin
        independent_instr = '0;
        for (int k = 0; k < BS; k++) begin
            independent_instr[k] = valid_q[k] & ~(|dep_q[k]);
        end
    end

    assign valid_entries = valid_q;
    assign occupancy     = occ_q;
    assign ins_error     = err_q;

endmodule

// File: tb/tb_esm_dep_tracker.sv
// Testbench for esm_dep_tracker. Four instances share one set of inputs,
// one for each DEP_MODE value, and all four are checked against one
// reference model.

module tb_esm_dep_tracker;

    localparam int BS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic [3:0]  ins_index;
    logic [31:0] ins_instr;
    logic        ins_regwrite;
    logic        ins_alusrc;
    logic        ret_valid;
    logic [3:0]  ret_index;
    logic        flush;

    logic [0:BS-1] dut_valid [4];
    logic [0:BS-1] dut_ind   [4];
    logic [4:0]    dut_occ   [4];
    logic          dut_err   [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            esm_dep_tracker #(
                .INSTR_W (32),
                .BS      (BS),
                .REGNUM  (32),
                .DEP_MODE(2'(g))
            ) u_dut (
                .clk              (clk),
                .rst              (rst),
                .ins_valid        (ins_valid),
                .ins_index        (ins_index),
                .ins_instr        (ins_instr),
                .ins_regwrite     (ins_regwrite),
                .ins_alusrc       (ins_alusrc),
                .ret_valid        (ret_valid),
                .ret_index        (ret_index),
                .flush            (flush),
                .valid_entries    (dut_valid[g]),
                .independent_instr(dut_ind[g]),
                .occupancy        (dut_occ[g]),
                .ins_error        (dut_err[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model. m_dep[mode][i][j] means that entry i waits for entry j.
    bit m_valid [BS];
    int m_rd    [BS];
    int m_rs1   [BS];
    int m_rs2   [BS];
    bit m_dep   [4][BS][BS];
    int m_occ;
    bit m_err;

    typedef struct {
        bit          iv;
        int          ii;
        int          rd;
        int          rs1;
        int          rs2;
        bit          rw;
        bit          alusrc;
        bit          rv;
        int          ri;
        bit          fl;
        logic [15:0] e_valid;
        logic [15:0] e_ind0;
        logic [15:0] e_ind3;
        int          e_occ;
        bit          e_err;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [31:0] make_instr(input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        w = $urandom;
        a = rd[4:0];
        b = rs1[4:0];
        c = rs2[4:0];
        w[11:7]  = a;
        w[19:15] = b;
        w[24:20] = c;
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < BS; k++) begin
            m_valid[k] = 1'b0;
            for (int m = 0; m < 4; m++)
                for (int j = 0; j < BS; j++)
                    m_dep[m][k][j] = 1'b0;
        end
        m_occ = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit iv, input int ii, input logic [31:0] instr,
                              input bit rw, input bit alusrc, input bit rv,
                              input int ri, input bit fl);
        bit eff;
        bit ok;
        int rd;
        int rs1;
        int rs2;
        bit d;
        if (fl) begin
            model_reset();
            return;
        end
        eff   = rv && m_valid[ri];
        ok    = iv && (!m_valid[ii] || (rv && ri == ii));
        m_err = iv && !ok;
        if (eff) begin
            m_valid[ri] = 1'b0;
            m_occ--;
            for (int m = 0; m < 4; m++)
                for (int k = 0; k < BS; k++) begin
                    m_dep[m][ri][k] = 1'b0;
                    m_dep[m][k][ri] = 1'b0;
                end
        end
        if (ok) begin
            rd  = rw ? int'(instr[11:7]) : 0;
            rs1 = int'(instr[19:15]);
            rs2 = alusrc ? 0 : int'(instr[24:20]);
            for (int m = 0; m < 4; m++) begin
                for (int j = 0; j < BS; j++) begin
                    d = 1'b0;
                    if (m_valid[j] && j != ii) begin
                        if (m_rd[j] != 0 && (m_rd[j] == rs1 || m_rd[j] == rs2)) d = 1'b1;
                        if ((m % 2) == 1 && rd != 0 && rd == m_rd[j]) d = 1'b1;
                        if ((m / 2) == 1 && rd != 0 && (rd == m_rs1[j] || rd == m_rs2[j])) d = 1'b1;
                    end
                    m_dep[m][ii][j] = d;
                end
            end
            m_valid[ii] = 1'b1;
            m_rd[ii]    = rd;
            m_rs1[ii]   = rs1;
            m_rs2[ii]   = rs2;
            m_occ++;
        end
    endtask

    function automatic logic [15:0] exp_valid();
        logic [0:15] v;
        v = '0;
        for (int k = 0; k < BS; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [15:0] exp_ind(input int m);
        logic [0:15] v;
        int waits;
        v = '0;
        for (int k = 0; k < BS; k++) begin
            waits = 0;
            for (int j = 0; j < BS; j++) waits += int'(m_dep[m][k][j]);
            v[k] = m_valid[k] && (waits == 0);
        end
        return v;
    endfunction

    task automatic cmp(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (mode %0d): got %h expected %h", name, inst, act, exp);
        end
    endtask

    // Compares every instance against the reference model.
    task automatic check_output(input string name);
        for (int m = 0; m < 4; m++) begin
            cmp({name, " valid"}, m, 32'(dut_valid[m]), 32'(exp_valid()));
            cmp({name, " indep"}, m, 32'(dut_ind[m]),   32'(exp_ind(m)));
            cmp({name, " occ"},   m, 32'(dut_occ[m]),   32'(m_occ));
            cmp({name, " err"},   m, 32'(dut_err[m]),   32'(m_err));
        end
    endtask

    task automatic idle_inputs();
        ins_valid    = 1'b0;
        ins_index    = '0;
        ins_instr    = '0;
        ins_regwrite = 1'b0;
        ins_alusrc   = 1'b0;
        ret_valid    = 1'b0;
        ret_index    = '0;
        flush        = 1'b0;
    endtask

    // Called at a falling edge. Drives one cycle of inputs and steps the
    // model on the rising edge. Returns at the next falling edge.
    task automatic apply_stimulus(input bit iv, input int ii, input logic [31:0] instr,
                                  input bit rw, input bit alusrc, input bit rv,
                                  input int ri, input bit fl);
        ins_valid    = iv;
        ins_index    = 4'(ii);
        ins_instr    = instr;
        ins_regwrite = rw;
        ins_alusrc   = alusrc;
        ret_valid    = rv;
        ret_index    = 4'(ri);
        flush        = fl;
        @(posedge clk);
        model_step(iv, ii, instr, rw, alusrc, rv, ri, fl);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        // iv ii rd rs1 rs2 rw alusrc rv ri fl | valid ind(mode0) ind(mode3) occ err
        tbl[0]  = '{1'b1, 0, 3, 1, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 1, 1'b0};
        tbl[1]  = '{1'b1, 1, 4, 3, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'hC000, 16'h8000, 16'h8000, 2, 1'b0};
        tbl[2]  = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 16'h4000, 16'h4000, 16'h4000, 1, 1'b0};
        tbl[3]  = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0};
        tbl[4]  = '{1'b1, 0, 7, 1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 1, 1'b0};
        tbl[5]  = '{1'b1, 1, 8, 7, 7, 1'b1, 1'b1, 1'b0, 0, 1'b0, 16'hC000, 16'hC000, 16'hC000, 2, 1'b0};
        tbl[6]  = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0};
        tbl[7]  = '{1'b1, 0, 5, 6, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 1, 1'b0};
        tbl[8]  = '{1'b1, 1, 5, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'hC000, 16'hC000, 16'h8000, 2, 1'b0};
        tbl[9]  = '{1'b1, 2, 6, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'hE000, 16'hE000, 16'h8000, 3, 1'b0};
        tbl[10] = '{1'b1, 0, 9, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'hE000, 16'hE000, 16'h8000, 3, 1'b1};
        tbl[11] = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'hE000, 16'hE000, 16'h8000, 3, 1'b0};
        tbl[12] = '{1'b1, 0, 7, 1, 2, 1'b1, 1'b0, 1'b1, 0, 1'b0, 16'hE000, 16'hE000, 16'hE000, 3, 1'b0};
        tbl[13] = '{1'b1, 3, 2, 1, 1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0};

        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_output("reset");
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i].iv, tbl[i].ii, make_instr(tbl[i].rd, tbl[i].rs1, tbl[i].rs2),
                           tbl[i].rw, tbl[i].alusrc, tbl[i].rv, tbl[i].ri, tbl[i].fl);
            check_output($sformatf("vec%0d model", i));
            cmp($sformatf("vec%0d valid", i), 0, 32'(dut_valid[0]), 32'(tbl[i].e_valid));
            cmp($sformatf("vec%0d ind", i),   0, 32'(dut_ind[0]),   32'(tbl[i].e_ind0));
            cmp($sformatf("vec%0d ind", i),   3, 32'(dut_ind[3]),   32'(tbl[i].e_ind3));
            cmp($sformatf("vec%0d occ", i),   3, 32'(dut_occ[3]),   32'(tbl[i].e_occ));
            cmp($sformatf("vec%0d err", i),   3, 32'(dut_err[3]),   32'(tbl[i].e_err));
        end

        // Fill every slot, then flush together with an insert and a retire
        for (int k = 0; k < BS; k++) begin
            apply_stimulus(1'b1, k, make_instr(k + 1, k, k + 2), 1'b1, 1'b0, 1'b0, 0, 1'b0);
            check_output("fill");
        end
        cmp("full occ",   0, 32'(dut_occ[0]),   32'd16);
        cmp("full valid", 0, 32'(dut_valid[0]), 32'h0000FFFF);
        apply_stimulus(1'b1, 5, make_instr(3, 4, 5), 1'b1, 1'b0, 1'b1, 2, 1'b1);
        check_output("flush full");
        cmp("flush occ",   0, 32'(dut_occ[0]),   32'd0);
        cmp("flush valid", 0, 32'(dut_valid[0]), 32'd0);
        cmp("flush ind",   0, 32'(dut_ind[0]),   32'd0);

        // Asynchronous reset pulse between clock edges
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, k * 4, make_instr(k + 1, 0, 0), 1'b1, 1'b0, 1'b0, 0, 1'b0);
        end
        check_output("pre async");
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int m = 0; m < 4; m++) begin
            cmp("async valid", m, 32'(dut_valid[m]), 32'd0);
            cmp("async ind",   m, 32'(dut_ind[m]),   32'd0);
            cmp("async occ",   m, 32'(dut_occ[m]),   32'd0);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("post async");

        // Random traffic over a small register range so hazards are common
        for (int n = 0; n < 600; n++) begin
            apply_stimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, BS - 1)),
                           make_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                      int'($urandom_range(0, 7))),
                           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 9) < 4), int'($urandom_range(0, BS - 1)),
                           ($urandom_range(0, 99) < 2));
            check_output("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/esm_dep_tracker.md
Name: esm_dep_tracker

Overview:
Parametrised successor to the ESM issue-analysis core. It merges register tracking and dependency tracking into one block with per-entry retirement and selectable hazard classes (RAW always; WAW and WAR optional). It also adds flush, occupancy and insert-error reporting. It sits between the instruction buffer and the issue scheduler and reports which buffered instructions are free to issue.

Parameters:
INSTR_W, 32, instruction word width; field positions are rd [11:7], rs1 [19:15], rs2 [24:20].
BS, 16, buffer entries; must be a power of 2, at least 2.
REGNUM, 32, architectural registers; register 0 never creates a dependency.
DEP_MODE, 2'b00, bit0 enables WAW tracking, bit1 enables WAR tracking.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
ins_valid  in  1  insert strobe.
ins_index  in  $clog2(BS)  target buffer slot.
ins_instr  in  INSTR_W  instruction word.
ins_regwrite  in  1  instruction writes rd; when 0, rd is treated as 0.
ins_alusrc  in  1  when 1, rs2 is unused and treated as 0.
ret_valid  in  1  retire strobe.
ret_index  in  $clog2(BS)  slot to retire.
flush  in  1  synchronous clear of all entries.
valid_entries  out  [0:BS-1]  occupied-slot mask.
independent_instr  out  [0:BS-1]  valid entries with no outstanding dependency.
occupancy  out  $clog2(BS+1)  number of valid entries.
ins_error  out  1  one-cycle pulse on a rejected insert.

Behaviour:
- State per slot: valid bit; rd, rs1, rs2 (each $clog2(REGNUM) bits, already masked); dependency row dep[i][0:BS-1].
- Reset (async): all valid bits, dep rows, occupancy and ins_error go to 0, so independent_instr = 0.
- Per-edge update order:
  - flush: clears everything exactly as reset does. It overrides insert and retire. ins_error = 0.
  - Retire: if ret_valid and valid[r], then valid[r] <= 0, dep[r] row <= 0, and column r <= 0 in every row. Retire of an invalid slot is ignored silently.
  - Insert: if ins_valid and (valid[i]==0, or ret_valid with ret_index==i), the slot is written and valid[i] <= 1. Otherwise the insert is ignored and ins_error pulses 1 for the next cycle.
  - A slot being retired in the same cycle is treated as already invalid for comparison. Its column is cleared in the new row.
- Dependency of a new entry i on an existing valid entry j (j≠i):
  - RAW: rd_j≠0 and (rd_j==rs1_i or rd_j==rs2_i).
  - WAW (DEP_MODE[0]): rd_i≠0 and rd_i==rd_j.
  - WAR (DEP_MODE[1]): rd_i≠0 and (rd_i==rs1_j or rd_i==rs2_j).
  - dep[i][j] is the OR of the enabled terms. dep[i][i] is always 0.
- All valid entries count as older than the entry being inserted. Dependencies are set only at insert time and cleared only by retire, flush or reset.
- Outputs:
  - independent_instr[k] = valid[k] & ~|dep[k].
  - valid_entries = valid.
  - All outputs are derived from registers only, with no combinational path from inputs. An insert or retire accepted at edge N is visible in the cycle after edge N.
- occupancy: +1 on an accepted insert, −1 on an effective retire, unchanged when both occur. It never exceeds BS and never wraps.
- Index comparison covers all $clog2(BS) bits. With power-of-2 BS, no out-of-range index exists.
- Reset asserted mid-operation: immediate clear, with no dependence on clk.

Test Plan:
1. Reset, then insert slot 0 (rd=3, rs1=1, rs2=2, regwrite=1, alusrc=0) -> next cycle: valid_entries=0x8000, independent_instr=0x8000, occupancy=1.
2. Scenario 1, then insert slot 1 (rd=4, rs1=3, rs2=5) -> independent_instr=0x8000. Then retire slot 0 -> valid_entries=0x4000, independent_instr=0x4000, occupancy=1.
3. x0 and masking: slot 0 with rd=0 (regwrite=0, instr field rd=7), then slot 1 with rs1=7 and alusrc=1 (rs2 field=7) -> slot 1 independent, independent_instr=0xC000.
4. DEP_MODE=2'b11:
   - slot 0 (rd=5, rs1=6), then slot 1 (rd=5) -> WAW, slot 1 dependent.
   - slot 2 (rd=6) -> WAR, slot 2 dependent.
   - Result: independent_instr=0x8000.
   - The same stimulus with DEP_MODE=0 gives 0xE000.
5. Insert to occupied slot 0 without retire -> ins_error=1 for one cycle, state unchanged. Retire 0 plus insert 0 in the same cycle -> accepted, occupancy unchanged, no self-dependency.
6. Fill all 16 slots -> occupancy=16. Flush in the same cycle as ins_valid/ret_valid -> all outputs 0. Async rst pulse between edges -> outputs 0 immediately.
